// File: rtl/alu_nibble_sequencer.sv
// Multi-cycle 4*WORDS-bit ALU sequencer: one nibble per clock, LSB nibble first, carry chained.
// Optional zero/overflow flags are built only when ALU_SEQ_FLAGS_EN is defined.
module alu_nibble_sequencer #(
    parameter int unsigned WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [4*WORDS-1:0]   a,
    input  logic [4*WORDS-1:0]   b,
    input  logic                 carry_in,
    output logic                 busy,
    output logic                 done,
    output logic [4*WORDS-1:0]   result,
    output logic                 cout,
    output logic                 zero,
    output logic                 ovf
);

    localparam int unsigned W  = 4 * WORDS;
    localparam int unsigned IW = $clog2(WORDS);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [IW-1:0] LastIdx = IW'(WORDS - 1);

    logic [1:0]    state_q;
    logic [IW-1:0] idx_q;
    logic          carry_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [1:0]    sel_q;
    logic [W-1:0]  acc_q;

    logic [1:0]    init_sel;
    logic          init_carry;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [3:0]    bmux;
    logic [3:0]    alu_d;
    logic          alu_cout;
    logic [W-1:0]  final_res;
    logic          last_nib;

    // Op decode into ALU B-mux select and the carry fed to the first nibble.
    always_comb begin
        init_sel   = 2'b10;
        init_carry = 1'b0;
        case (op)
            3'b001:  begin init_sel = 2'b10; init_carry = 1'b1;     end
            3'b010:  begin init_sel = 2'b00; init_carry = 1'b0;     end
            3'b011:  begin init_sel = 2'b00; init_carry = carry_in; end
            3'b100:  begin init_sel = 2'b01; init_carry = 1'b1;     end
            3'b101:  begin init_sel = 2'b01; init_carry = carry_in; end
            3'b110:  begin init_sel = 2'b11; init_carry = 1'b0;     end
            default: begin init_sel = 2'b10; init_carry = 1'b0;     end
        endcase
    end

    // Shared 4-bit ALU datapath: D = A + Bmux + Cin.
    assign a_sh  = a_q >> {idx_q, 2'b00};
    assign b_sh  = b_q >> {idx_q, 2'b00};
    assign a_nib = a_sh[3:0];
    assign b_nib = b_sh[3:0];

    always_comb begin
        case (sel_q)
            2'b00:   bmux = b_nib;
            2'b01:   bmux = ~b_nib;
            2'b10:   bmux = 4'h0;
            default: bmux = 4'hF;
        endcase
    end

    assign {alu_cout, alu_d} = {1'b0, a_nib} + {1'b0, bmux} + {4'b0000, carry_q};

    // The top nibble lands in the accumulator on the same edge result is loaded.
    assign final_res = {alu_d, acc_q[W-5:0]};
    assign last_nib  = (state_q == StRun) && (idx_q == LastIdx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 2'b10;
            acc_q   <= '0;
            result  <= '0;
            cout    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        sel_q   <= init_sel;
                        carry_q <= init_carry;
                        idx_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    acc_q[{idx_q, 2'b00} +: 4] <= alu_d;
                    carry_q <= alu_cout;
                    idx_q   <= idx_q + IW'(1);
                    if (idx_q == LastIdx) begin
                        result  <= final_res;
                        cout    <= alu_cout;
                        idx_q   <= '0;
                        state_q <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else if (last_nib) begin
            zero <= (final_res == '0);
            ovf  <= (a_q[W-1] == bmux[3]) && (alu_d[3] != a_q[W-1]);
        end
    end
`else
    assign zero = 1'b0;
    assign ovf  = 1'b0;
`endif

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Scoreboard bench for alu_nibble_sequencer (WORDS=4); flag expectations follow ALU_SEQ_FLAGS_EN.
module tb_alu_nibble_sequencer;

`ifdef ALU_SEQ_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        z;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        carry_in = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic        zero;
    logic        ovf;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    alu_nibble_sequencer #(.WORDS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .carry_in(carry_in),
        .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] r, input logic c, input logic z, input logic v);
        exp_t e;
        e.res = r;
        e.c   = c;
        e.z   = z & FLAGS;
        e.v   = v & FLAGS;
        sb.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", 32'(result), 32'(e.res));
                    check("cout", 32'(cout), 32'(e.c));
                    check("zero", 32'(zero), 32'(e.z));
                    check("ovf", 32'(ovf), 32'(e.v));
                end
            end
        end
    end

    // Issue one op from IDLE (called at a negedge) and check latency/busy length.
    task automatic run_op(input logic [2:0] o, input logic [15:0] va, input logic [15:0] vb,
                          input logic ci, input logic [15:0] r, input logic c,
                          input logic z, input logic v);
        int lat;
        int bcnt;
        op = o; a = va; b = vb; carry_in = ci; start = 1'b1;
        push(r, c, z, v);
        @(posedge clk);
        #1 start = 1'b0;
        lat  = 0;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) break;
            if (lat > 20) break;
            @(posedge clk);
            lat++;
        end
        check("done_latency", 32'(lat), 32'd4);
        check("busy_cycles", 32'(bcnt), 32'd5);
        @(negedge clk);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        int nd;
        int dt[3];
        int dcnt;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(3'b010, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0); // ADD
        run_op(3'b100, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0); // SUB
        run_op(3'b001, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0); // INC
        run_op(3'b110, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0); // DEC
        run_op(3'b010, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1); // ADD ovf
        run_op(3'b011, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0); // ADC
        run_op(3'b000, 16'hABCD, 16'h5555, 1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0); // TFR
        run_op(3'b111, 16'h1357, 16'h2468, 1'b0, 16'h1357, 1'b0, 1'b0, 1'b0); // reserved
        run_op(3'b101, 16'h0010, 16'h0001, 1'b0, 16'h000E, 1'b1, 1'b0, 1'b0); // SBB

        // start held high; a changes during the first RUN and is picked up only on re-accept
        op = 3'b010; a = 16'h0001; b = 16'h0001; carry_in = 1'b0; start = 1'b1;
        push(16'h0002, 1'b0, 1'b0, 1'b0);
        push(16'h0011, 1'b0, 1'b0, 1'b0);
        push(16'h0011, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 a = 16'h0010;
        cyc  = 0;
        dcnt = 0;
        while (dcnt < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                dt[dcnt] = cyc;
                dcnt++;
            end
        end
        start = 1'b0;
        check("held_done_count", 32'(dcnt), 32'd3);
        check("held_spacing1", 32'(dt[1] - dt[0]), 32'd6);
        check("held_spacing2", 32'(dt[2] - dt[1]), 32'd6);
        @(negedge clk);
        @(negedge clk);
        check("held_idle", 32'(busy), 32'd0);

        // reset during the second RUN cycle abandons the op
        op = 3'b010; a = 16'h1111; b = 16'h2222; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort_no_done", 32'(nd), 32'd0);
        run_op(3'b010, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
